ctrl_interrupciones: RTL

- Interrupt controller that sequences the single-cycle CPU datapath's interrupt entry and exit.
- Captures requests from the four I/O ports, applies a CPU-written mask, and arbitrates one winner.
- Drives a one-cycle PC-redirect pulse plus a 10-bit vector address to the datapath and UC.
- Holds off further entries until the UC signals end-of-ISR. No nesting.

---
 rtl/ctrl_interrupciones_pkg.sv | 24 ++
 rtl/ctrl_interrupciones_prio_enc4.sv | 29 ++
 rtl/ctrl_interrupciones.sv | 115 +++++++++++
 3 files changed

// File: rtl/ctrl_interrupciones_pkg.sv
// Shared definitions for the interrupt controller: sizes, FSM state encoding
// and the ISR vector address helper.
package ctrl_interrupciones_pkg;

  localparam int unsigned NUM_INT = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned VEC_W   = 10;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPATCH = 2'd1,
    SERVICE  = 2'd2
  } int_state_t;

  // ISR entry point for a given port; wraps modulo 2**VEC_W.
  function automatic logic [VEC_W-1:0] vec_addr(input logic [VEC_W-1:0] base,
                                                input logic [VEC_W-1:0] stride,
                                                input logic [ID_W-1:0]  id);
    logic [VEC_W-1:0] offs;
    offs = VEC_W'(VEC_W'(id) * stride);
    return VEC_W'(base + offs);
  endfunction

endpackage

// File: rtl/ctrl_interrupciones_prio_enc4.sv
// Combinational 4-to-2 priority encoder; the search begins at index 'start'
// and wraps, so start=0 gives fixed lowest-index-wins priority.
module prio_enc4
  import ctrl_interrupciones_pkg::*;
(
  input  logic [NUM_INT-1:0] req,
  input  logic [ID_W-1:0]    start,
  output logic [ID_W-1:0]    id,
  output logic               any
);

  logic            found;
  logic [ID_W-1:0] idx;

  always_comb begin
    id    = '0;
    found = 1'b0;
    idx   = '0;
    any   = |req;
    for (int k = 0; k < NUM_INT; k++) begin
      idx = ID_W'(start + ID_W'(k));
      if (!found && req[idx]) begin
        id    = idx;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ctrl_interrupciones.sv
// Interrupt controller: edge capture, mask, arbitration and ISR entry/exit
// sequencing. Define CTRL_INT_ROUND_ROBIN_EN for rotating priority.
module ctrl_interrupciones
  import ctrl_interrupciones_pkg::*;
#(
  parameter logic [VEC_W-1:0]   VEC_BASE   = 10'h3C0,
  parameter logic [VEC_W-1:0]   VEC_STRIDE = 10'h010,
  parameter logic [NUM_INT-1:0] MASK_RST   = 4'hF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_INT-1:0] int_in,
  input  logic               mask_we,
  input  logic [NUM_INT-1:0] mask_d,
  input  logic               fin_int,
  output logic               int_pulse,
  output logic [VEC_W-1:0]   vector,
  output logic               in_service,
  output logic [ID_W-1:0]    active_id,
  output logic [NUM_INT-1:0] pending
);

  int_state_t         state;
  logic [NUM_INT-1:0] hist;
  logic [NUM_INT-1:0] mask;
  logic [NUM_INT-1:0] edge_det;
  logic [NUM_INT-1:0] eligible;
  logic [NUM_INT-1:0] take_mask;
  logic [ID_W-1:0]    win_id;
  logic [ID_W-1:0]    start;
  logic               win_any;
  logic               take;

  assign edge_det  = int_in & ~hist;
  assign eligible  = pending & mask;
  assign take      = (state == IDLE) && win_any;
  assign take_mask = take ? NUM_INT'(1'b1) << win_id : '0;

`ifdef CTRL_INT_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id;

  // Most recently dispatched port drops to lowest priority.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_id <= ID_W'(NUM_INT - 1);
    end else if (take) begin
      last_id <= win_id;
    end
  end

  assign start = ID_W'(last_id + ID_W'(1));
`else
  assign start = '0;
`endif

  prio_enc4 u_prio (
    .req   (eligible),
    .start (start),
    .id    (win_id),
    .any   (win_any)
  );

  // Request capture and mask; a new edge wins over the clear of a taken bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hist    <= '1;
      pending <= '0;
      mask    <= MASK_RST;
    end else begin
      hist    <= int_in;
      pending <= (pending & ~take_mask) | edge_det;
      if (mask_we) begin
        mask <= mask_d;
      end
    end
  end

  // Entry/exit sequencer with registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      int_pulse  <= 1'b0;
      in_service <= 1'b0;
      active_id  <= '0;
      vector     <= VEC_BASE;
    end else begin
      int_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (win_any) begin
            active_id  <= win_id;
            vector     <= vec_addr(VEC_BASE, VEC_STRIDE, win_id);
            int_pulse  <= 1'b1;
            in_service <= 1'b1;
            state      <= DISPATCH;
          end
        end
        DISPATCH: begin
          state <= SERVICE;
        end
        SERVICE: begin
          if (fin_int) begin
            in_service <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          in_service <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
